// File: rtl/instruction_decode_stage_if.sv
// instruction_decode_stage_if: fetch-side, register-file, writeback and ALU-side signals of the decode stage
interface instruction_decode_stage_if #(
  parameter int XLEN = 32,
  parameter int PC_W = 32
);
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     instr;
  logic [PC_W-1:0] in_pc;
  logic [4:0]      rs1_addr;
  logic [4:0]      rs2_addr;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic            wb_we;
  logic [4:0]      wb_addr;
  logic [XLEN-1:0] wb_data;
  logic            out_valid;
  logic            out_ready;
  logic [4:0]      rd_addr;
  logic [6:0]      opcode_out;
  logic [2:0]      funct3_out;
  logic [6:0]      funct7_out;
  logic [XLEN-1:0] opd1;
  logic [XLEN-1:0] opd2;
  logic [XLEN-1:0] opd3;
  logic [XLEN-1:0] opd4;
  logic [PC_W-1:0] out_pc;
  logic            illegal;
  modport slave (
    input  flush, in_valid, instr, in_pc, rs1_data, rs2_data, wb_we, wb_addr, wb_data, out_ready,
    output in_ready, rs1_addr, rs2_addr, out_valid, rd_addr, opcode_out, funct3_out, funct7_out,
           opd1, opd2, opd3, opd4, out_pc, illegal
  );
  modport master (
    output flush, in_valid, instr, in_pc, rs1_data, rs2_data, wb_we, wb_addr, wb_data, out_ready,
    input  in_ready, rs1_addr, rs2_addr, out_valid, rd_addr, opcode_out, funct3_out, funct7_out,
           opd1, opd2, opd3, opd4, out_pc, illegal
  );
endinterface

// File: rtl/instruction_decode_stage.sv
// instruction_decode_stage: RV32I decode with WB bypass, immediate extension and a registered valid/ready output
module instruction_decode_stage #(
  parameter int XLEN   = 32,
  parameter bit FWD_EN = 1'b1,
  parameter int PC_W   = 32
) (
  input logic clk,
  input logic rst,
  instruction_decode_stage_if.slave bus
);
  localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LOAD = 7'b0000011,
                         OP_S = 7'b0100011, OP_B = 7'b1100011, OP_JAL = 7'b1101111,
                         OP_JALR = 7'b1100111, OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111;
  logic [31:0] i;
  logic [6:0] op;
  logic is_r, is_i, is_s, is_b, is_jal, is_lui, is_auipc, legal, use_rs1, use_rs2, take;
  logic [31:0] imm32;
  logic [XLEN-1:0] imm, rs1_v, rs2_v, pc_x, opd1_d, opd2_d, opd3_d, opd4_d;
  logic [4:0] rd_d;
  assign i        = bus.instr;
  assign op       = i[6:0];
  assign is_r     = op == OP_R;
  assign is_i     = op == OP_I || op == OP_LOAD || op == OP_JALR;
  assign is_s     = op == OP_S;
  assign is_b     = op == OP_B;
  assign is_jal   = op == OP_JAL;
  assign is_lui   = op == OP_LUI;
  assign is_auipc = op == OP_AUIPC;
  assign legal    = is_r | is_i | is_s | is_b | is_jal | is_lui | is_auipc;
  assign use_rs1  = is_r | is_i | is_s | is_b;
  assign use_rs2  = is_r | is_s | is_b;
  assign bus.rs1_addr = use_rs1 ? i[19:15] : 5'd0;
  assign bus.rs2_addr = use_rs2 ? i[24:20] : 5'd0;
  assign bus.in_ready = !bus.out_valid | bus.out_ready;
  assign take         = bus.in_valid & bus.in_ready;
  assign pc_x         = XLEN'(bus.in_pc);
  // Operand selection; x0 is never bypassed since its architectural value is always zero
  always_comb begin
    rs1_v = (FWD_EN && bus.wb_we && bus.wb_addr == bus.rs1_addr && bus.wb_addr != 5'd0) ? bus.wb_data : bus.rs1_data;
    rs2_v = (FWD_EN && bus.wb_we && bus.wb_addr == bus.rs2_addr && bus.wb_addr != 5'd0) ? bus.wb_data : bus.rs2_data;
    imm32 = is_i     ? {{20{i[31]}}, i[31:20]} :
            is_s     ? {{20{i[31]}}, i[31:25], i[11:7]} :
            is_b     ? {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0} :
            is_jal   ? {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0} :
            (is_lui | is_auipc) ? {i[31:12], 12'b0} : 32'd0;
    imm    = XLEN'($signed(imm32));
    opd1_d = (is_r | is_i | is_s) ? rs1_v : is_lui ? imm : is_auipc ? pc_x : '0;
    opd2_d = is_r ? rs2_v : (is_i | is_s | is_b | is_jal | is_auipc) ? imm : '0;
    opd3_d = is_s ? rs2_v : is_b ? rs1_v : '0;
    opd4_d = is_b ? rs2_v : '0;
    rd_d   = (is_r | is_i | is_jal | is_lui | is_auipc) ? i[11:7] : 5'd0;
  end
  // Output pipeline register: flush beats capture, capture beats drain
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.out_valid  <= 1'b0;
      bus.rd_addr    <= '0;
      bus.opcode_out <= '0;
      bus.funct3_out <= '0;
      bus.funct7_out <= '0;
      bus.opd1       <= '0;
      bus.opd2       <= '0;
      bus.opd3       <= '0;
      bus.opd4       <= '0;
      bus.out_pc     <= '0;
      bus.illegal    <= 1'b0;
    end else if (bus.flush) begin
      bus.out_valid <= 1'b0;
    end else if (take) begin
      bus.out_valid  <= 1'b1;
      bus.rd_addr    <= rd_d;
      bus.opcode_out <= op;
      bus.funct3_out <= i[14:12];
      bus.funct7_out <= i[31:25];
      bus.opd1       <= opd1_d;
      bus.opd2       <= opd2_d;
      bus.opd3       <= opd3_d;
      bus.opd4       <= opd4_d;
      bus.out_pc     <= bus.in_pc;
      bus.illegal    <= !legal;
    end else if (bus.out_ready) begin
      bus.out_valid <= 1'b0;
    end
  end
endmodule
